// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer.
//   wb_state_type : upstream request FSM states
//   wb_entry_type : one buffered store (address, data, byte strobes)
//   wb_in_type    : upstream request bundle from the execute stage
//   wb_out_type   : upstream completion bundle back to the execute stage
package store_write_buffer_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_XLEN  = 32;
    localparam int WB_STRB  = WB_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_ST = 2'd1,
        DRAIN   = 2'd2,
        LOAD    = 2'd3
    } wb_state_type;

    typedef struct packed {
        logic [WB_XLEN-1:0] addr;
        logic [WB_XLEN-1:0] wdata;
        logic [WB_STRB-1:0] wstrb;
    } wb_entry_type;

    typedef struct packed {
        logic         valid;
        logic         fence;
        wb_entry_type ent;
    } wb_in_type;

    typedef struct packed {
        logic               ready;
        logic [WB_XLEN-1:0] rdata;
    } wb_out_type;

endpackage

// File: rtl/store_write_buffer_wb_fifo.sv
// Circular buffer of DEPTH store entries.
//   clk_i, rst_i   : clock, synchronous active-high reset (pointers/count only)
//   push_i, data_i : enqueue data_i at the tail
//   pop_i          : dequeue the head (caller guarantees non-empty)
//   head_o         : current head entry
//   count_o        : occupied entries, full_o / empty_o derived from it
// A push while full is only legal together with a pop; the count is then unchanged.
module wb_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wb_entry_type             data_i,
    input  logic                     pop_i,
    output wb_entry_type             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_type    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the execute stage and the data-memory port.
// Stores are posted into a FIFO and acked at once; loads and fences wait
// until every older store has drained, so memory order is preserved.
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/fence/addr/wdata/wstrb: one-cycle upstream request (wstrb==0 -> load)
//   mem_ready, mem_rdata            : one-cycle completion pulse, load data
//   dmem_valid/addr/wdata/wstrb     : downstream request (wstrb==0 -> read)
//   dmem_ready, dmem_rdata          : downstream completion, read data
//   wb_empty, wb_count              : buffer status
// XLEN must match WB_XLEN, the width the entry types are built with.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int XLEN  = WB_XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_fence,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [XLEN/8-1:0]      req_wstrb,
    output logic                   mem_ready,
    output logic [XLEN-1:0]        mem_rdata,
    output logic                   dmem_valid,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [XLEN-1:0]        dmem_wdata,
    output logic [XLEN/8-1:0]      dmem_wstrb,
    input  logic                   dmem_ready,
    input  logic [XLEN-1:0]        dmem_rdata,
    output logic                   wb_empty,
    output logic [$clog2(DEPTH):0] wb_count
);

    wb_state_type    state_q, state_d;
    logic            pend_fence_q, pend_fence_d;
    wb_entry_type    pend_ent_q, pend_ent_d;
    logic            ack_q, ack_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    wb_in_type       req;
    wb_out_type      up;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty, drain_act;
    wb_entry_type    fifo_push_data, fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

    always_comb begin
        req.valid     = req_valid;
        req.fence     = req_fence;
        req.ent.addr  = req_addr;
        req.ent.wdata = req_wdata;
        req.ent.wstrb = req_wstrb;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_push_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_fence_q <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_fence_q <= pend_fence_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_ent_q <= pend_ent_d;
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        pend_fence_d   = pend_fence_q;
        pend_ent_d     = pend_ent_q;
        ack_d          = 1'b0;
        rdata_d        = '0;
        fifo_push      = 1'b0;
        fifo_push_data = req.ent;
        case (state_q)
            IDLE: begin
                if (req.valid) begin
                    if (!req.fence && (req.ent.wstrb != '0)) begin
                        if (!fifo_full) begin
                            fifo_push = 1'b1;
                            ack_d     = 1'b1;
                        end else begin
                            pend_fence_d = 1'b0;
                            pend_ent_d   = req.ent;
                            state_d      = PEND_ST;
                        end
                    end else begin
                        pend_fence_d = req.fence;
                        pend_ent_d   = req.ent;
                        state_d      = DRAIN;
                    end
                end
            end
            PEND_ST: begin
                // The slot freed by this cycle's pop is refilled at once.
                fifo_push_data = pend_ent_q;
                if (fifo_pop) begin
                    fifo_push = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = pend_fence_q ? IDLE : LOAD;
                end
            end
            LOAD: begin
                if (dmem_ready) begin
                    ack_d   = 1'b1;
                    rdata_d = dmem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: drain engine owns the port unless a load is in progress.
    always_comb begin
        drain_act  = !fifo_empty && (state_q != LOAD);
        fifo_pop   = drain_act && dmem_ready;
        dmem_valid = drain_act || (state_q == LOAD);
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        if (state_q == LOAD) begin
            dmem_addr = pend_ent_q.addr;
        end else if (drain_act) begin
            dmem_addr  = fifo_head.addr;
            dmem_wdata = fifo_head.wdata;
            dmem_wstrb = fifo_head.wstrb;
        end
        // A fence finding the buffer empty is acked in the same cycle, so an
        // already-empty buffer gives the ack one cycle after the request.
        up.ready  = ack_q || ((state_q == DRAIN) && pend_fence_q && fifo_empty);
        up.rdata  = rdata_q;
        mem_ready = up.ready;
        mem_rdata = up.rdata;
        wb_empty  = fifo_empty;
        wb_count  = fifo_count;
    end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_fence;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        dmem_valid;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_empty;
    logic [2:0]  wb_count;

    int checks = 0;
    int errors = 0;

    // 0: bench drives dmem_ready directly, 1: ready after 3 wait cycles, 2: random
    int resp_mode = 0;
    int wait_cnt  = 0;

    logic [31:0] model_mem [256];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [3:0]  log_s[$];

    store_write_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_fence  (req_fence),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .wb_empty   (wb_empty),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    assign dmem_rdata = (dmem_valid && dmem_wstrb == 4'h0) ? model_mem[dmem_addr[9:2]] : 32'h0;

    // Downstream transfers complete at the next rising edge; record them mid-cycle.
    always @(negedge clk) begin
        if (dmem_valid && dmem_ready) begin
            log_a.push_back(dmem_addr);
            log_d.push_back(dmem_wdata);
            log_s.push_back(dmem_wstrb);
            if (dmem_wstrb != 4'h0) model_mem[dmem_addr[9:2]] = dmem_wdata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (resp_mode == 1) begin
            if (dmem_valid) begin
                if (wait_cnt == 3) begin
                    dmem_ready = 1'b1;
                    wait_cnt   = 0;
                end else begin
                    dmem_ready = 1'b0;
                    wait_cnt   = wait_cnt + 1;
                end
            end else begin
                dmem_ready = 1'b0;
            end
        end else if (resp_mode == 2) begin
            dmem_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic fence, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        req_fence = fence;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_fence = 1'b0;
        req_wstrb = 4'h0;
    endtask

    // Called right after send(); lat counts cycles since req_valid.
    task automatic wait_ack(output int lat, output logic [31:0] rd);
        lat = 1;
        while (!mem_ready && lat < 60) begin
            tick();
            lat++;
        end
        rd = mem_rdata;
        check("ack_seen", {31'd0, mem_ready}, 32'd1);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_s.delete();
    endtask

    int          lat;
    logic [31:0] rd;
    int          nreads;
    int          guard;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_fence = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0; dmem_ready = 1'b0;
        tick(); tick();
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_dmem_valid", {31'd0, dmem_valid}, 32'd0);
        check("rst_wb_empty", {31'd0, wb_empty}, 32'd1);
        check("rst_wb_count", {29'd0, wb_count}, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Store burst with an always-ready memory
        dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF);
            wait_ack(lat, rd);
            check("burst_lat", 32'(lat), 32'd1);
        end
        repeat (3) tick();
        check("burst_nwrites", 32'(log_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            check("burst_addr", log_a[i], 32'h100 + 32'(4 * i));
            check("burst_data", log_d[i], 32'hA000 + 32'(i));
        end
        check("burst_empty", {31'd0, wb_empty}, 32'd1);

        // Full FIFO: fifth store waits for the first pop
        clear_log();
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'h400 + 32'(4 * i), 32'hB000 + 32'(i), 4'hF);
            wait_ack(lat, rd);
            check("full_lat", 32'(lat), 32'd1);
        end
        send(1'b0, 32'h410, 32'hB004, 4'hF);
        check("pend_noack", {31'd0, mem_ready}, 32'd0);
        check("full_count", {29'd0, wb_count}, 32'd4);
        tick(); tick();
        check("pend_still_noack", {31'd0, mem_ready}, 32'd0);
        dmem_ready = 1'b1;
        tick();
        check("pend_ack", {31'd0, mem_ready}, 32'd1);
        check("pend_count_hold", {29'd0, wb_count}, 32'd4);
        tick();
        check("pend_single_ack", {31'd0, mem_ready}, 32'd0);
        repeat (6) tick();
        check("full_nwrites", 32'(log_a.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_a.size(); i++)
            check("full_addr", log_a[i], 32'h400 + 32'(4 * i));
        check("full_empty", {31'd0, wb_empty}, 32'd1);

        // Load after store: read only after the write completes
        clear_log();
        dmem_ready = 1'b0;
        send(1'b0, 32'h200, 32'hDEADBEEF, 4'hF);
        wait_ack(lat, rd);
        check("ls_store_lat", 32'(lat), 32'd1);
        send(1'b0, 32'h200, 32'h0, 4'h0);
        tick(); tick();
        check("ls_blocked", {31'd0, mem_ready}, 32'd0);
        check("ls_head_is_write", {28'd0, dmem_wstrb}, 32'hF);
        dmem_ready = 1'b1;
        wait_ack(lat, rd);
        check("ls_rdata", rd, 32'hDEADBEEF);
        check("ls_ntransfers", 32'(log_a.size()), 32'd2);
        if (log_a.size() >= 2) begin
            check("ls_first_write", {28'd0, log_s[0]}, 32'hF);
            check("ls_second_read", {28'd0, log_s[1]}, 32'h0);
            check("ls_read_addr", log_a[1], 32'h200);
        end
        tick();
        check("ls_rdata_zero", mem_rdata, 32'h0);

        // Fence behind two slow stores
        clear_log();
        dmem_ready = 1'b0;
        send(1'b0, 32'h500, 32'hC000, 4'hF);
        wait_ack(lat, rd);
        send(1'b0, 32'h504, 32'hC001, 4'hF);
        wait_ack(lat, rd);
        resp_mode = 1;
        wait_cnt  = 0;
        send(1'b1, 32'h0, 32'h0, 4'h0);
        wait_ack(lat, rd);
        check("fence_writes_done", 32'(log_a.size()), 32'd2);
        nreads = 0;
        foreach (log_s[i]) if (log_s[i] == 4'h0) nreads++;
        check("fence_no_read", 32'(nreads), 32'd0);
        check("fence_empty", {31'd0, wb_empty}, 32'd1);
        tick();
        send(1'b1, 32'h0, 32'h0, 4'h0);
        check("fence_empty_lat1", {31'd0, mem_ready}, 32'd1);
        resp_mode = 0;
        tick();
        dmem_ready = 1'b0;

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h600 + 32'(4 * i), 32'hD000, 4'hF);
            wait_ack(lat, rd);
        end
        check("mid_count", {29'd0, wb_count}, 32'd3);
        check("mid_valid", {31'd0, dmem_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("rstd_valid", {31'd0, dmem_valid}, 32'd0);
        check("rstd_count", {29'd0, wb_count}, 32'd0);
        check("rstd_empty", {31'd0, wb_empty}, 32'd1);
        check("rstd_mem_ready", {31'd0, mem_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // Wrap-around under random downstream backpressure
        clear_log();
        resp_mode = 2;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 32'h300 + 32'(4 * i), 32'hE000 + 32'(i), 4'hF);
            wait_ack(lat, rd);
        end
        guard = 0;
        while (!wb_empty && guard < 200) begin
            tick();
            guard++;
        end
        resp_mode = 0;
        tick();
        dmem_ready = 1'b0;
        check("wrap_empty", {31'd0, wb_empty}, 32'd1);
        check("wrap_nwrites", 32'(log_a.size()), 32'd10);
        for (int i = 0; i < 10 && i < log_a.size(); i++) begin
            check("wrap_addr", log_a[i], 32'h300 + 32'(4 * i));
            check("wrap_data", log_d[i], 32'hE000 + 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
